// File: rtl/cordic_pkg.sv
// ============================================================================
//  Module   : cordic_pkg
//  Purpose  : Shared constants, FSM state encoding and a small helper for the
//             CORDIC request arbiter.
//  Contents : CORDIC_WIDTH / CORDIC_FRAC_BITS  fixed-point format (1.0 = 2^20)
//             PI, HALF_PI                       angle constants in that format
//             arb_state_t                       arbiter FSM states
//             onehot_index()                    one-hot (<= 8 bit) to index
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package cordic_pkg;

   localparam int CORDIC_WIDTH     = 24;
   localparam int CORDIC_FRAC_BITS = 20;

   localparam logic [23:0] PI      = 24'h3243F6;
   localparam logic [23:0] HALF_PI = 24'h1921FB;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } arb_state_t;

   // Index of the set bit of a one-hot vector; 0 when the vector is empty.
   function automatic int onehot_index(input logic [7:0] vec);
      int idx;
      idx = 0;
      for (int i = 0; i < 8; i++) begin
         if (vec[i]) idx = i;
      end
      return idx;
   endfunction

endpackage : cordic_pkg

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin selector. The request at index ptr has
//             highest priority, then ascending indices with wrap-around.
//  Ports    : req    in   N_REQ      request vector
//             ptr    in   clog2(N)   highest-priority index (must be < N_REQ)
//             grant  out  N_REQ      one-hot grant, all-zero when no request
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]         req,
   input  logic [$clog2(N_REQ)-1:0] ptr,
   output logic [N_REQ-1:0]         grant
);

   localparam int ID_W = $clog2(N_REQ);

   logic found;
   int   idx;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = 0;
      // Walk from ptr upward, wrapping once; the first asserted request wins.
      for (int k = 0; k < N_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!found && req[ID_W'(idx)]) begin
            grant[ID_W'(idx)] = 1'b1;
            found             = 1'b1;
         end
      end
   end

endmodule : rr_arbiter

`default_nettype wire

// File: rtl/cordic_arbiter.sv
// ============================================================================
//  Module   : cordic_arbiter
//  Purpose  : Shares one external CORDIC core between N_REQ requesters. A
//             round-robin winner is accepted in IDLE, its angle is presented
//             to the core with a one-cycle start pulse, the rising edge of the
//             core's done level is captured, and a one-cycle response strobe
//             carries cosine/sine plus the served port index.
//  Ports    : clk, rst                 clock, synchronous active-high reset
//             req_valid/req_angle      per-port request (port i at i*WIDTH)
//             req_ready                one-hot accept (IDLE only)
//             rsp_valid/rsp_id/x/y     result strobe, port index, cos, sin
//             cor_angle/cor_data_loaded  angle and start pulse to the core
//             cor_x/cor_y/cor_data_computed  core results and done level
//  Config   : CORDIC_ARB_RANGE_REDUCE_EN  folds |angle| > pi/2 into range and
//             negates the cosine of folded requests.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cordic_arbiter
   import cordic_pkg::*;
#(
   parameter int WIDTH = CORDIC_WIDTH,
   parameter int N_REQ = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [N_REQ*WIDTH-1:0]   req_angle,
   output logic [N_REQ-1:0]         req_ready,
   output logic                     rsp_valid,
   output logic [$clog2(N_REQ)-1:0] rsp_id,
   output logic [WIDTH-1:0]         rsp_x,
   output logic [WIDTH-1:0]         rsp_y,
   output logic [WIDTH-1:0]         cor_angle,
   output logic                     cor_data_loaded,
   input  logic [WIDTH-1:0]         cor_x,
   input  logic [WIDTH-1:0]         cor_y,
   input  logic                     cor_data_computed
);

   localparam int ID_W = $clog2(N_REQ);

   arb_state_t        state;
   logic [ID_W-1:0]   ptr;
   logic [ID_W-1:0]   cur_id;
   logic [N_REQ-1:0]  grant;
   logic [ID_W-1:0]   grant_idx;
   logic [WIDTH-1:0]  sel_angle;
   logic [WIDTH-1:0]  core_angle;
   logic              comp_prev;

   rr_arbiter #(
      .N_REQ (N_REQ)
   ) u_rr (
      .req   (req_valid),
      .ptr   (ptr),
      .grant (grant)
   );

   always_comb begin
      grant_idx = ID_W'(onehot_index(8'(grant)));
      sel_angle = req_angle[grant_idx*WIDTH +: WIDTH];
   end

   // Accept is combinational so a winner is taken on the same cycle it is seen.
   assign req_ready = (state == ST_IDLE && !rst) ? grant : '0;

`ifdef CORDIC_ARB_RANGE_REDUCE_EN
   localparam logic signed [WIDTH-1:0] PI_S   = $signed(WIDTH'(PI));
   localparam logic signed [WIDTH-1:0] HALF_S = $signed(WIDTH'(HALF_PI));

   logic signed [WIDTH-1:0] sel_s;
   logic                    fold_next;
   logic                    fold;

   // Reflect about +/- pi/2: cos changes sign, sin is unchanged.
   always_comb begin
      sel_s      = $signed(sel_angle);
      core_angle = sel_angle;
      fold_next  = 1'b0;
      if (sel_s > HALF_S) begin
         core_angle = PI_S - sel_s;
         fold_next  = 1'b1;
      end else if (sel_s < -HALF_S) begin
         core_angle = -PI_S - sel_s;
         fold_next  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fold <= 1'b0;
      end else if (state == ST_IDLE && |grant) begin
         fold <= fold_next;
      end
   end
`else
   assign core_angle = sel_angle;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= ST_IDLE;
         ptr             <= '0;
         cur_id          <= '0;
         comp_prev       <= 1'b0;
         rsp_valid       <= 1'b0;
         rsp_id          <= '0;
         rsp_x           <= '0;
         rsp_y           <= '0;
         cor_angle       <= '0;
         cor_data_loaded <= 1'b0;
      end else begin
         // Sampled every cycle so a level already high when WAIT is entered
         // is not mistaken for a fresh completion.
         comp_prev       <= cor_data_computed;
         cor_data_loaded <= 1'b0;
         rsp_valid       <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (|grant) begin
                  cor_angle       <= core_angle;
                  cur_id          <= grant_idx;
                  ptr             <= (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
                  cor_data_loaded <= 1'b1;
                  state           <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (cor_data_computed && !comp_prev) begin
`ifdef CORDIC_ARB_RANGE_REDUCE_EN
                  rsp_x <= fold ? (~cor_x + 1'b1) : cor_x;
`else
                  rsp_x <= cor_x;
`endif
                  rsp_y     <= cor_y;
                  rsp_id    <= cur_id;
                  rsp_valid <= 1'b1;
                  state     <= ST_RESP;
               end
            end
            ST_RESP: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule : cordic_arbiter

`default_nettype wire

// File: tb/tb_cordic_arbiter.sv
// ============================================================================
//  Module   : tb_cordic_arbiter
//  Purpose  : Self-checking bench for cordic_arbiter with a behavioural core
//             model, a round-robin reference and a response scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cordic_arbiter;

   localparam int W  = 24;
   localparam int N  = 4;
   localparam int IW = 2;

   logic              clk;
   logic              rst;
   logic [N-1:0]      req_valid;
   logic [N*W-1:0]    req_angle;
   logic [N-1:0]      req_ready;
   logic              rsp_valid;
   logic [IW-1:0]     rsp_id;
   logic [W-1:0]      rsp_x;
   logic [W-1:0]      rsp_y;
   logic [W-1:0]      cor_angle;
   logic              cor_data_loaded;
   logic [W-1:0]      cor_x;
   logic [W-1:0]      cor_y;
   logic              cor_data_computed;

   cordic_arbiter #(.WIDTH(W), .N_REQ(N)) dut (
      .clk               (clk),
      .rst               (rst),
      .req_valid         (req_valid),
      .req_angle         (req_angle),
      .req_ready         (req_ready),
      .rsp_valid         (rsp_valid),
      .rsp_id            (rsp_id),
      .rsp_x             (rsp_x),
      .rsp_y             (rsp_y),
      .cor_angle         (cor_angle),
      .cor_data_loaded   (cor_data_loaded),
      .cor_x             (cor_x),
      .cor_y             (cor_y),
      .cor_data_computed (cor_data_computed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         id;
      logic [W-1:0] x;
      logic [W-1:0] y;
   } exp_t;

   exp_t sb[$];
   int   order_q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   rise_cyc = 0;
   int   rsp_cnt = 0;
   bit   busy = 1'b0;
   int   ptr_m = 0;
   bit   exp_load = 1'b0;
   logic [W-1:0] exp_cangle = '0;
   logic [W-1:0] last_y = '0;
   int   last_id = 0;
   int   acc_cnt[N];
   int   done_cnt[N];
   int   remaining[N];
   bit   core_en = 1'b1;
   int   core_lat = 5;
   int   cnt = 0;
   int   hi = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Behavioural core results: sin/cos of 1.0 rad for that angle, otherwise an
   // arbitrary but distinguishable mapping.
   function automatic logic [W-1:0] core_x(input logic [W-1:0] a);
      if (a == 24'h100000) return 24'h08A51B;
      return ~a + 24'h000111;
   endfunction

   function automatic logic [W-1:0] core_y(input logic [W-1:0] a);
      if (a == 24'h100000) return 24'h0D76AA;
      return a ^ 24'h0F0F0F;
   endfunction

   function automatic logic [N-1:0] rr_model(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++) begin
         if (v[(p + k) % N]) return N'(1) << ((p + k) % N);
      end
      return '0;
   endfunction

   function automatic logic [W-1:0] fold_ang(input logic [W-1:0] a, output bit neg);
      int s;
      s   = int'($signed(a));
      neg = 1'b0;
`ifdef CORDIC_ARB_RANGE_REDUCE_EN
      if (s > 32'sh1921FB) begin
         neg = 1'b1;
         return W'(32'sh3243F6 - s);
      end
      if (s < -32'sh1921FB) begin
         neg = 1'b1;
         return W'(-32'sh3243F6 - s);
      end
`endif
      return a;
   endfunction

   function automatic logic [W-1:0] rand_angle();
      int r;
      r = int'($urandom_range(0, 2 * 32'h1921FB));
      return W'(r - 32'sh1921FB);
   endfunction

   // Reference monitor: checks accept, start pulse, core angle and responses.
   always @(negedge clk) begin
      logic [N-1:0] er;
      logic [W-1:0] a;
      logic [W-1:0] ca;
      bit           neg;
      exp_t         e;
      int           g;
      if (rst) begin
         sb.delete();
         busy     = 1'b0;
         ptr_m    = 0;
         exp_load = 1'b0;
      end else begin
         chk("load_pulse", 32'(cor_data_loaded), 32'(exp_load));
         exp_load = 1'b0;
         if (busy) chk("cor_angle", 32'(cor_angle), 32'(exp_cangle));
         er = busy ? '0 : rr_model(req_valid, ptr_m);
         chk("req_ready", 32'(req_ready), 32'(er));
         if (er != '0) begin
            g = 0;
            for (int i = 0; i < N; i++) if (er[i]) g = i;
            a  = req_angle[g*W +: W];
            ca = fold_ang(a, neg);
            e.id = g;
            e.x  = neg ? (~core_x(ca) + 1'b1) : core_x(ca);
            e.y  = core_y(ca);
            sb.push_back(e);
            exp_cangle = ca;
            exp_load   = 1'b1;
            busy       = 1'b1;
            ptr_m      = (g + 1) % N;
            acc_cnt[g]++;
            order_q.push_back(g);
         end
         if (rsp_valid) begin
            rsp_cnt++;
            last_y  = rsp_y;
            last_id = int'(rsp_id);
            if (sb.size() == 0) begin
               chk("spurious_rsp", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("rsp_id", 32'(rsp_id), 32'(e.id));
               chk("rsp_x", 32'(rsp_x), 32'(e.x));
               chk("rsp_y", 32'(rsp_y), 32'(e.y));
               chk("rsp_latency", 32'(cyc - rise_cyc), 32'd1);
               busy = 1'b0;
            end
         end
      end
   end

   // One clock: retire accepted requests and step the core model.
   task automatic tick();
      @(posedge clk);
      #1;
      for (int p = 0; p < N; p++) begin
         if (acc_cnt[p] != done_cnt[p]) begin
            done_cnt[p]++;
            if (remaining[p] > 0) begin
               remaining[p]--;
               req_angle[p*W +: W] = rand_angle();
            end else begin
               req_valid[p] = 1'b0;
            end
         end
      end
      if (hi > 0) begin
         hi--;
         if (hi == 0) cor_data_computed = 1'b0;
      end
      if (core_en) begin
         if (cor_data_loaded) begin
            cnt = core_lat;
         end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               cor_x             = core_x(cor_angle);
               cor_y             = core_y(cor_angle);
               cor_data_computed = 1'b1;
               rise_cyc          = cyc;
               hi                = 3;
            end
         end
      end
   endtask

   task automatic set_req(input int p, input logic [W-1:0] a, input int rem);
      req_angle[p*W +: W] = a;
      remaining[p]        = rem;
      req_valid[p]        = 1'b1;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 3000; i++) begin
         if (!busy && req_valid == '0 && sb.size() == 0) return;
         tick();
      end
      chk("timeout", 32'd1, 32'd0);
   endtask

   int base;

   initial begin
      for (int p = 0; p < N; p++) begin
         acc_cnt[p] = 0; done_cnt[p] = 0; remaining[p] = 0;
      end
      rst = 1'b1;
      req_valid = '0;
      req_angle = '0;
      cor_x = '0;
      cor_y = '0;
      cor_data_computed = 1'b0;

      // All four ports valid while in reset, then release.
      for (int p = 0; p < N; p++) set_req(p, rand_angle(), 0);
      repeat (3) tick();
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_load", 32'(cor_data_loaded), 32'd0);
      chk("rst_cor_angle", 32'(cor_angle), 32'd0);
      order_q.delete();
      rst = 1'b0;
      wait_done();
      chk("order_len", 32'(order_q.size()), 32'd4);
      for (int i = 0; i < 4; i++) chk("order_all4", 32'(order_q[i]), 32'(i));

      // Port 2 asks for 1.0 rad, core answers after 30 cycles; a request on
      // port 1 is raised and withdrawn while port 2 is in flight.
      core_lat = 30;
      base = rsp_cnt;
      set_req(2, 24'h100000, 0);
      repeat (4) tick();
      req_angle[1*W +: W] = 24'h012345;
      req_valid[1] = 1'b1;
      repeat (2) tick();
      req_valid[1] = 1'b0;
      wait_done();
      chk("sin1_count", 32'(rsp_cnt - base), 32'd1);
      chk("sin1_id", 32'(last_id), 32'd2);
      chk("sin1_y", 32'(last_y), 32'h0D76AA);

      // Ports 0 and 1 continuously valid: service must alternate.
      core_lat = 6;
      order_q.delete();
      set_req(0, rand_angle(), 3);
      set_req(1, rand_angle(), 3);
      wait_done();
      chk("alt_len", 32'(order_q.size()), 32'd8);
      for (int i = 1; i < order_q.size(); i++)
         chk("alt_no_repeat", 32'(order_q[i] != order_q[i-1]), 32'd1);

      // Done level already high when WAIT is entered.
      core_en = 1'b0;
      cor_x = core_x(24'h050000);
      cor_y = core_y(24'h050000);
      cor_data_computed = 1'b1;
      base = rsp_cnt;
      set_req(1, 24'h050000, 0);
      repeat (20) tick();
      chk("held_high_no_rsp", 32'(rsp_cnt - base), 32'd0);
      cor_data_computed = 1'b0;
      tick();
      cor_data_computed = 1'b1;
      rise_cyc = cyc;
      repeat (6) tick();
      chk("held_high_one_rsp", 32'(rsp_cnt - base), 32'd1);
      cor_data_computed = 1'b0;
      core_en = 1'b1;
      wait_done();

      // Reset for one cycle while waiting on the core; the stale completion
      // then arrives in IDLE and must be ignored.
      core_lat = 30;
      base = rsp_cnt;
      set_req(2, rand_angle(), 0);
      repeat (12) tick();
      rst = 1'b1;
      tick();
      chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("mid_rst_rsp_id", 32'(rsp_id), 32'd0);
      chk("mid_rst_rsp_x", 32'(rsp_x), 32'd0);
      chk("mid_rst_rsp_y", 32'(rsp_y), 32'd0);
      chk("mid_rst_cor_angle", 32'(cor_angle), 32'd0);
      chk("mid_rst_load", 32'(cor_data_loaded), 32'd0);
      rst = 1'b0;
      repeat (40) tick();
      chk("mid_rst_no_rsp", 32'(rsp_cnt - base), 32'd0);
      core_lat = 8;
      set_req(3, rand_angle(), 0);
      wait_done();
      chk("after_rst_served", 32'(rsp_cnt - base), 32'd1);
      chk("after_rst_id", 32'(last_id), 32'd3);

`ifdef CORDIC_ARB_RANGE_REDUCE_EN
      // Angles beyond pi/2 are folded before reaching the core.
      set_req(0, 24'h200000, 0);
      for (int i = 0; i < 50 && !cor_data_loaded; i++) tick();
      chk("fold_pos_angle", 32'(cor_angle), 32'h1243F6);
      wait_done();
      set_req(1, 24'hE00000, 0);
      for (int i = 0; i < 50 && !cor_data_loaded; i++) tick();
      chk("fold_neg_angle", 32'(cor_angle), 32'hEDBC0A);
      wait_done();
`endif

      repeat (3) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

endmodule : tb_cordic_arbiter

`default_nettype wire

// File: doc/cordic_arbiter.md
CORDIC_ARBITER -- requirements
Module: cordic_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 24, meaning angle/result width in signed fixed point with 20 fraction bits (1.0 = 0x100000).
REQ-002 The block SHALL have parameter N_REQ, default 4, meaning the number of requester ports (2..8).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 Ports SHALL be:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  N_REQ  per-port request
- req_angle  in  N_REQ*WIDTH  per-port angle; port i in bits [i*WIDTH +: WIDTH]
- req_ready  out  N_REQ  one-hot accept
- rsp_valid  out  1  one-cycle result strobe
- rsp_id  out  $clog2(N_REQ)  index of the served port
- rsp_x  out  WIDTH  cosine result
- rsp_y  out  WIDTH  sine result
- cor_angle  out  WIDTH  angle to the CORDIC core
- cor_data_loaded  out  1  start pulse to the core
- cor_x, cor_y  in  WIDTH  core results
- cor_data_computed  in  1  core done level

Function
REQ-005 The FSM SHALL have states IDLE, LOAD, WAIT and RESP.
REQ-006 IDLE: req_ready[g] SHALL be 1 only for the round-robin winner g among asserted req_valid; on that accept edge, the block SHALL register the angle and g and move to LOAD.
REQ-007 Round robin: the highest priority SHALL go to the pointer index, then ascending with wrap; after a grant to g, the pointer SHALL become (g+1) mod N_REQ.
REQ-008 LOAD: cor_angle SHALL hold the registered angle, and cor_data_loaded SHALL be 1 for exactly this one cycle; the next state SHALL be WAIT.
REQ-009 cor_angle SHALL stay stable from LOAD until the block leaves WAIT.
REQ-010 WAIT: the block SHALL detect a rising edge of cor_data_computed (registered previous value 0, current 1).
- A level already high on entry SHALL NOT count.
- On the edge, the block SHALL capture cor_x and cor_y and move to RESP.
REQ-011 RESP: rsp_valid SHALL be 1 for exactly one cycle with rsp_id, rsp_x and rsp_y valid; the next state SHALL be IDLE.
REQ-012 Latency SHALL be accept edge T -> LOAD at T+1 -> rsp_valid at (edge cycle)+1. No backpressure on rsp.
REQ-013 Only one request SHALL be in flight; req_ready SHALL be all-zero outside IDLE.
REQ-014 A requester SHALL hold req_valid and req_angle stable until it sees req_ready; dropping req_valid before acceptance SHALL withdraw the request without effect.
REQ-015 rsp_x, rsp_y and rsp_id SHALL hold their last value outside RESP.

Reset
REQ-016 While rst=1, the block SHALL force:
- state IDLE, pointer 0
- req_ready 0, rsp_valid 0, rsp_id 0, rsp_x 0, rsp_y 0
- cor_angle 0, cor_data_loaded 0
- edge-detect register 0
REQ-017 Reset mid-operation SHALL discard the in-flight request with no rsp_valid; a later cor_data_computed edge seen in IDLE SHALL be ignored.

Configuration
REQ-018 With CORDIC_ARB_RANGE_REDUCE_EN defined, the block SHALL fold the angle at accept:
- angle > HALF_PI: core angle = PI - angle
- angle < -HALF_PI: core angle = -PI - angle
- a fold flag SHALL be stored; when it is set, rsp_x SHALL be -cor_x (two's complement) and rsp_y SHALL be cor_y unchanged.
- Valid input range SHALL be [-PI, PI].
REQ-019 Without CORDIC_ARB_RANGE_REDUCE_EN, the angle SHALL pass through unchanged, results SHALL be unmodified, and the result for |angle| > HALF_PI is unspecified.

Structure
REQ-020 Package cordic_pkg SHALL hold:
- the WIDTH and fraction-bit constants
- PI = 24'h3243F6 and HALF_PI = 24'h1921FB
- the FSM state enum
REQ-021 Round-robin selection SHALL be a sub-module rr_arbiter (N_REQ-wide request, pointer in, one-hot grant out); the CORDIC core SHALL be instantiated outside this block.

Verification
REQ-022 Port 2 requests angle 0x100000, with the core model responding after 30 cycles -> cor_angle=0x100000, cor_data_loaded high one cycle, rsp_valid one cycle with rsp_id=2 and rsp_y=0x0D76AA.
REQ-023 All four ports valid from reset release -> grants in order 0,1,2,3, with rsp_id matching each, and no overlap of in-flight requests.
REQ-024 Ports 0 and 1 continuously valid -> service alternates 0,1,0,1; no port is served twice in a row.
REQ-025 rst asserted for one cycle during WAIT -> no rsp_valid, all outputs zero, and a subsequent request on port 3 is served normally.
REQ-026 cor_data_computed held high when WAIT is entered -> no response until it falls and rises again, then exactly one rsp_valid.
REQ-027 With CORDIC_ARB_RANGE_REDUCE_EN defined, angle 0x200000 -> cor_angle=0x1243F6 and rsp_x equal to the negated cor_x; angle -0x200000 -> cor_angle=0xEDBC0A.
